// File: rtl/alu_decode_stage.sv
// Purpose: decode RV32I instructions into ALU control, operands and writeback/memory/branch control.
// Latency: 1 cycle from an accepted input to out_valid.
// Backpressure: 2-entry skid buffer keeps in_ready a pure flop output; out_* hold while stalled.
module alu_decode_stage #(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_con,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_mem_rd,
  output logic            out_mem_wr,
  output logic            out_branch,
  output logic [2:0]      out_funct3,
  output logic            out_illegal
);

  localparam logic [3:0] CON_ADD   = 4'b0000;
  localparam logic [3:0] CON_SUB   = 4'b0001;
  localparam logic [3:0] CON_AND   = 4'b0010;
  localparam logic [3:0] CON_OR    = 4'b0011;
  localparam logic [3:0] CON_XOR   = 4'b0100;
  localparam logic [3:0] CON_SLT   = 4'b0101;
  localparam logic [3:0] CON_SLTU  = 4'b0110;
  localparam logic [3:0] CON_AUIPC = 4'b1000;
  localparam logic [3:0] CON_LUI   = 4'b1001;
  localparam logic [3:0] CON_SLL   = 4'b1010;
  localparam logic [3:0] CON_SRA   = 4'b1011;
  localparam logic [3:0] CON_SRL   = 4'b1100;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [3:0]      con;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic            we;
    logic            mem_rd;
    logic            mem_wr;
    logic            branch;
    logic [2:0]      funct3;
    logic            illegal;
  } dec_t;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      rd;
  logic            alt;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt_i, shamt_r;

  assign opc     = in_instr[6:0];
  assign rd      = in_instr[11:7];
  assign f3      = in_instr[14:12];
  assign f7      = in_instr[31:25];
  assign alt     = (f7 == 7'b0100000);
  assign imm_i   = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u   = {in_instr[31:12], 12'b0};
  assign imm_j   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  // The ALU shifts by the full B, so shift amounts are zero-extended from 5 bits.
  assign shamt_i = {27'b0, in_instr[24:20]};
  assign shamt_r = {27'b0, in_rs2_data[4:0]};

  dec_t dec;
  logic ill;

  // Combinational decode of the presented instruction.
  always_comb begin
    dec          = '0;
    ill          = 1'b0;
    dec.rs2_data = in_rs2_data;
    dec.rd       = rd;
    dec.funct3   = f3;
    case (opc)
      OPC_OP: begin
        dec.a  = in_rs1_data;
        dec.b  = in_rs2_data;
        dec.we = 1'b1;
        ill    = !((f7 == 7'b0) || alt);
        case (f3)
          3'd0: dec.con = alt ? CON_SUB : CON_ADD;
          3'd1: begin dec.con = CON_SLL;  dec.b = shamt_r; ill = ill | alt; end
          3'd2: begin dec.con = CON_SLT;  ill = ill | alt; end
          3'd3: begin dec.con = CON_SLTU; ill = ill | alt; end
          3'd4: begin dec.con = CON_XOR;  ill = ill | alt; end
          3'd5: begin dec.con = alt ? CON_SRA : CON_SRL; dec.b = shamt_r; end
          3'd6: begin dec.con = CON_OR;   ill = ill | alt; end
          3'd7: begin dec.con = CON_AND;  ill = ill | alt; end
        endcase
      end
      OPC_OPIMM: begin
        dec.a  = in_rs1_data;
        dec.b  = imm_i;
        dec.we = 1'b1;
        case (f3)
          3'd0: dec.con = CON_ADD;
          3'd1: begin dec.con = CON_SLL; dec.b = shamt_i; ill = (f7 != 7'b0); end
          3'd2: dec.con = CON_SLT;
          3'd3: dec.con = CON_SLTU;
          3'd4: dec.con = CON_XOR;
          3'd5: begin
            dec.con = alt ? CON_SRA : CON_SRL;
            dec.b   = shamt_i;
            ill     = !((f7 == 7'b0) || alt);
          end
          3'd6: dec.con = CON_OR;
          3'd7: dec.con = CON_AND;
        endcase
      end
      OPC_LUI: begin
        dec.con = CON_LUI;
        dec.b   = imm_u;
        dec.we  = 1'b1;
      end
      OPC_AUIPC: begin
        dec.con = CON_AUIPC;
        dec.a   = in_pc;
        dec.b   = imm_u;
        dec.we  = 1'b1;
      end
      OPC_LOAD: begin
        dec.a      = in_rs1_data;
        dec.b      = imm_i;
        dec.we     = 1'b1;
        dec.mem_rd = 1'b1;
        ill        = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      OPC_STORE: begin
        dec.a      = in_rs1_data;
        dec.b      = imm_s;
        dec.mem_wr = 1'b1;
        ill        = (f3 > 3'd2);
      end
      OPC_BRANCH: begin
        dec.a      = in_rs1_data;
        dec.b      = in_rs2_data;
        dec.imm    = imm_b;
        dec.branch = 1'b1;
        case (f3[2:1])
          2'b00:   dec.con = CON_SUB;
          2'b10:   dec.con = CON_SLT;
          2'b11:   dec.con = CON_SLTU;
          default: ill = 1'b1;
        endcase
      end
      OPC_JAL, OPC_JALR: begin
        dec.a   = in_pc;
        dec.b   = 32'd4;
        dec.imm = (opc == OPC_JAL) ? imm_j : imm_i;
        dec.we  = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      dec.con     = CON_ADD;
      dec.a       = '0;
      dec.b       = '0;
      dec.imm     = '0;
      dec.we      = 1'b0;
      dec.mem_rd  = 1'b0;
      dec.mem_wr  = 1'b0;
      dec.branch  = 1'b0;
      dec.illegal = 1'b1;
    end
    dec.we = dec.we & (rd != 5'd0);
  end

  dec_t out_q, skid_q;
  logic out_vld, skid_vld;
  logic acc, xfer;

  // in_ready is just the inverted skid-occupied flop when the skid is enabled.
  assign in_ready = SKID_EN ? !skid_vld : (!out_vld || out_ready);
  assign acc      = in_valid && in_ready && !flush;
  assign xfer     = out_vld && out_ready;

  // Output register plus skid entry; the skid always drains into the output first (FIFO order).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= '0;
      out_vld  <= 1'b0;
      skid_q   <= '0;
      skid_vld <= 1'b0;
    end else if (flush) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
    end else if (!out_vld || xfer) begin
      if (skid_vld) begin
        out_q    <= skid_q;
        out_vld  <= 1'b1;
        skid_vld <= 1'b0;
      end else if (acc) begin
        out_q   <= dec;
        out_vld <= 1'b1;
      end else begin
        out_vld <= 1'b0;
      end
    end else if (acc && SKID_EN) begin
      skid_q   <= dec;
      skid_vld <= 1'b1;
    end
  end

  assign out_valid    = out_vld;
  assign out_con      = out_q.con;
  assign out_a        = out_q.a;
  assign out_b        = out_q.b;
  assign out_rs2_data = out_q.rs2_data;
  assign out_imm      = out_q.imm;
  assign out_rd       = out_q.rd;
  assign out_we       = out_q.we;
  assign out_mem_rd   = out_q.mem_rd;
  assign out_mem_wr   = out_q.mem_wr;
  assign out_branch   = out_q.branch;
  assign out_funct3   = out_q.funct3;
  assign out_illegal  = out_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Purpose: directed self-checking bench for alu_decode_stage.
// Latency: expects outputs one cycle after each accepted input.
// Backpressure: exercises stall, skid fill/drain, flush and mid-transfer reset.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_con;
  logic [31:0] out_a, out_b, out_rs2_data, out_imm;
  logic [4:0]  out_rd;
  logic        out_we, out_mem_rd, out_mem_wr, out_branch, out_illegal;
  logic [2:0]  out_funct3;

  int total = 0;
  int bad   = 0;

  alu_decode_stage #(.XLEN(32), .SKID_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_con(out_con), .out_a(out_a), .out_b(out_b),
    .out_rs2_data(out_rs2_data), .out_imm(out_imm), .out_rd(out_rd),
    .out_we(out_we), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
    .out_branch(out_branch), .out_funct3(out_funct3), .out_illegal(out_illegal)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single cycle; the decoded entry is visible on return.
  task automatic send(input logic [31:0] i, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2);
    in_valid    = 1'b1;
    in_instr    = i;
    in_pc       = pc;
    in_rs1_data = r1;
    in_rs2_data = r2;
    tick();
    in_valid    = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b1;
    in_instr    = 32'h002081B3;
    in_pc       = 32'h0;
    in_rs1_data = 32'd5;
    in_rs2_data = 32'd7;
    out_ready   = 1'b1;

    // Reset with input valid held high.
    tick();
    tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_out_con", {28'b0, out_con}, 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    tick();
    chk("post_rst_idle", {31'b0, out_valid}, 32'd0);

    // add x3,x1,x2
    send(32'h002081B3, 32'h0, 32'd5, 32'd7);
    chk("add_valid", {31'b0, out_valid}, 32'd1);
    chk("add_con", {28'b0, out_con}, 32'h0);
    chk("add_a", out_a, 32'd5);
    chk("add_b", out_b, 32'd7);
    chk("add_rd", {27'b0, out_rd}, 32'd3);
    chk("add_we", {31'b0, out_we}, 32'd1);
    tick();
    chk("add_drained", {31'b0, out_valid}, 32'd0);

    // sub x3,x1,x2
    send(32'h402081B3, 32'h0, 32'd5, 32'd7);
    chk("sub_con", {28'b0, out_con}, 32'h1);

    // add x0,x1,x2 : write suppressed
    send(32'h00208033, 32'h0, 32'd1, 32'd2);
    chk("rd0_we", {31'b0, out_we}, 32'd0);

    // srai x5,x1,3
    send(32'h4030D293, 32'h0, 32'hFFFF0000, 32'h0);
    chk("srai_con", {28'b0, out_con}, 32'hB);
    chk("srai_b", out_b, 32'h00000003);
    chk("srai_rd", {27'b0, out_rd}, 32'd5);

    // sll x3,x1,x2 with rs2 above 31: B keeps only the low 5 bits
    send(32'h002091B3, 32'h0, 32'd1, 32'hFFFFFFE3);
    chk("sll_con", {28'b0, out_con}, 32'hA);
    chk("sll_b", out_b, 32'h00000003);

    // lui x1,0x12345
    send(32'h123450B7, 32'h0, 32'h55, 32'h0);
    chk("lui_con", {28'b0, out_con}, 32'h9);
    chk("lui_b", out_b, 32'h12345000);
    chk("lui_a", out_a, 32'h0);

    // auipc x2,1 at pc 0x100
    send(32'h00001117, 32'h100, 32'h0, 32'h0);
    chk("auipc_con", {28'b0, out_con}, 32'h8);
    chk("auipc_a", out_a, 32'h100);
    chk("auipc_b", out_b, 32'h1000);

    // lw x4,12(x1)
    send(32'h00C0A203, 32'h0, 32'h2000, 32'h0);
    chk("lw_mem_rd", {31'b0, out_mem_rd}, 32'd1);
    chk("lw_b", out_b, 32'd12);
    chk("lw_we", {31'b0, out_we}, 32'd1);

    // sw x2,8(x1)
    send(32'h0020A423, 32'h0, 32'h3000, 32'hCAFEF00D);
    chk("sw_con", {28'b0, out_con}, 32'h0);
    chk("sw_mem_wr", {31'b0, out_mem_wr}, 32'd1);
    chk("sw_we", {31'b0, out_we}, 32'd0);
    chk("sw_b", out_b, 32'd8);
    chk("sw_a", out_a, 32'h3000);
    chk("sw_data", out_rs2_data, 32'hCAFEF00D);

    // beq x1,x2,+8
    send(32'h00208463, 32'h0, 32'd9, 32'd9);
    chk("beq_con", {28'b0, out_con}, 32'h1);
    chk("beq_branch", {31'b0, out_branch}, 32'd1);
    chk("beq_imm", out_imm, 32'd8);
    chk("beq_we", {31'b0, out_we}, 32'd0);

    // jal x1,+16 at pc 0x40
    send(32'h010000EF, 32'h40, 32'h0, 32'h0);
    chk("jal_a", out_a, 32'h40);
    chk("jal_b", out_b, 32'd4);
    chk("jal_imm", out_imm, 32'd16);
    chk("jal_we", {31'b0, out_we}, 32'd1);

    // Illegal encodings
    send(32'h00000000, 32'h0, 32'h0, 32'h0);
    chk("ill0_flag", {31'b0, out_illegal}, 32'd1);
    chk("ill0_we", {31'b0, out_we}, 32'd0);
    send(32'hFFFFFFFF, 32'h0, 32'h0, 32'h0);
    chk("illF_flag", {31'b0, out_illegal}, 32'd1);
    chk("illF_we", {31'b0, out_we}, 32'd0);
    send(32'h022081B3, 32'h0, 32'h0, 32'h0);
    chk("illf7_flag", {31'b0, out_illegal}, 32'd1);
    chk("illf7_con", {28'b0, out_con}, 32'h0);
    tick();

    // Backpressure: three back-to-back instructions with the output stalled.
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    in_instr    = 32'h002081B3;
    tick();
    chk("bp_first_rd", {27'b0, out_rd}, 32'd3);
    chk("bp_first_rdy", {31'b0, in_ready}, 32'd1);
    in_instr    = 32'h00208233;
    tick();
    chk("bp_skid_rdy", {31'b0, in_ready}, 32'd0);
    chk("bp_hold_rd", {27'b0, out_rd}, 32'd3);
    in_instr    = 32'h002082B3;
    tick();
    chk("bp_stall_rd", {27'b0, out_rd}, 32'd3);
    chk("bp_stall_vld", {31'b0, out_valid}, 32'd1);
    out_ready   = 1'b1;
    tick();
    chk("bp_second_rd", {27'b0, out_rd}, 32'd4);
    chk("bp_rdy_back", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid    = 1'b0;
    chk("bp_third_rd", {27'b0, out_rd}, 32'd5);
    chk("bp_third_vld", {31'b0, out_valid}, 32'd1);
    tick();
    chk("bp_empty", {31'b0, out_valid}, 32'd0);

    // Flush with two entries buffered and a new input presented in the flush cycle.
    out_ready = 1'b0;
    send(32'h002081B3, 32'h0, 32'd1, 32'd1);
    send(32'h00208233, 32'h0, 32'd1, 32'd1);
    in_valid  = 1'b1;
    in_instr  = 32'h002082B3;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    chk("flush_vld", {31'b0, out_valid}, 32'd0);
    chk("flush_rdy", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick();
    tick();
    chk("flush_no_stale", {31'b0, out_valid}, 32'd0);
    send(32'h123450B7, 32'h0, 32'h0, 32'h0);
    chk("flush_fresh_rd", {27'b0, out_rd}, 32'd1);
    chk("flush_fresh_con", {28'b0, out_con}, 32'h9);
    tick();

    // Reset while entries are buffered.
    out_ready = 1'b0;
    send(32'h002081B3, 32'h0, 32'd1, 32'd1);
    send(32'h00208233, 32'h0, 32'd1, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_vld", {31'b0, out_valid}, 32'd0);
    chk("mrst_rdy", {31'b0, in_ready}, 32'd1);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    chk("mrst_idle", {31'b0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Decode stage feeding the RV32I ALU: takes fetched instructions plus register-file read data and produces the ALU's 4-bit control code, operands A/B and writeback/memory/branch control.
- Output is registered behind a valid/ready handshake with a 2-entry skid buffer, so in_ready is a pure flop output.
- Sits between the fetch stage and the execute stage.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- SKID_EN, 1, 1 gives a 2-entry skid buffer; 0 gives a single output register with in_ready = !out_valid | out_ready.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous; drops all buffered entries.
- in_valid  input  1  instruction/operands valid.
- in_ready  output  1  stage can accept.
- in_instr  input  32  instruction word.
- in_pc  input  32  instruction address.
- in_rs1_data  input  32  rs1 read data.
- in_rs2_data  input  32  rs2 read data.
- out_valid  output  1  decoded entry valid.
- out_ready  input  1  execute stage accepts.
- out_con  output  4  ALU control code.
- out_a  output  32  ALU operand A.
- out_b  output  32  ALU operand B.
- out_rs2_data  output  32  store data.
- out_imm  output  32  B/J immediate for target calculation.
- out_rd  output  5  destination register.
- out_we  output  1  register write enable; forced 0 when rd = 0.
- out_mem_rd  output  1  load.
- out_mem_wr  output  1  store.
- out_branch  output  1  conditional branch.
- out_funct3  output  3  passthrough funct3.
- out_illegal  output  1  unsupported encoding.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid = 0, in_ready = 1, skid empty, all data outputs 0.
- ALU control codes:
  - 0000 add; 0001 sub; 0010 and; 0011 or; 0100 xor; 0101 slt; 0110 sltu.
  - 1000 A + upper(B) (AUIPC); 1001 upper(B) (LUI).
  - 1010 sll; 1011 sra; 1100 srl.
  - 0111 is never emitted.
- OP (0110011): funct3/funct7 select add/sub (f7 0100000 = sub), sll, slt, sltu, xor, srl/sra (f7 0100000 = sra), or, and. A = rs1, B = rs2. Any other funct7 is illegal.
- OP-IMM (0010011): same mapping with B = sign-extended I-immediate, except:
  - there is no subi;
  - shifts take B = {27'b0, shamt}, with funct7 0000000 (slli/srli) or 0100000 (srai) only.
- Shift operands (OP and OP-IMM): B[31:5] is always 0, because the ALU shifts by the full B.
- LUI: con 1001, B = {imm[31:12], 12'b0}, A = 0.
- AUIPC: con 1000, A = pc, B = U-immediate.
- LOAD: con 0000, A = rs1, B = I-immediate, mem_rd = 1. funct3 3/6/7 are illegal.
- STORE: con 0000, A = rs1, B = S-immediate, mem_wr = 1, we = 0. funct3 > 2 is illegal.
- BRANCH (we = 0, branch = 1, A = rs1, B = rs2, imm = B-immediate):
  - beq/bne use con 0001;
  - blt/bge use 0101;
  - bltu/bgeu use 0110;
  - funct3 2/3 are illegal.
- JAL/JALR: con 0000, A = pc, B = 4 (link value), we = 1, imm = J-immediate (JAL) or I-immediate (JALR).
- Any other opcode, or an illegal funct field: out_illegal = 1, we = mem_rd = mem_wr = branch = 0, con = 0000. The entry still flows through the stage.
- Latency: 1 cycle from an accepted input (in_valid & in_ready) to out_valid.
- Handshake: out_* hold stable while out_valid & !out_ready. No combinational path from out_ready to in_ready.
- Skid buffer (SKID_EN = 1):
  - Input accepted while output is stalled → goes to the skid entry and in_ready drops the next cycle.
  - On the next output transfer the skid entry moves to the output register and in_ready rises.
  - Ordering is strictly FIFO.
- Simultaneous output transfer and input accept with the skid empty: the output register loads the new entry and out_valid stays 1.
- Flush: out_valid = 0, skid emptied, in_ready = 1 next cycle. Any input presented in the flush cycle is discarded. Flush overrides accept.
- Reset mid-transfer: all entries are lost and no output is produced after rst_n deasserts until a new input is accepted.

Test Plan:
- Reset: rst_n = 0 with in_valid = 1 → out_valid = 0, in_ready = 1; after release, nothing is emitted until a new input is accepted.
- Register ALU ops: instr 0x002081B3 (add x3,x1,x2), rs1 = 5, rs2 = 7 → con 0000, A = 5, B = 7, rd = 3, we = 1, one cycle later. Instr 0x402081B3 → con 0001.
- Immediate shift and U-type:
  - 0x4030D293 (srai x5,x1,3) → con 1011, B = 0x00000003, rd = 5.
  - 0x123450B7 (lui x1) → con 1001, B = 0x12345000.
  - AUIPC at pc 0x100 → con 1000, A = 0x100.
- Memory and branch: 0x0020A423 (sw) → con 0000, mem_wr = 1, we = 0, B = 8. 0x00208463 (beq) → con 0001, branch = 1, imm = 8.
- Backpressure: hold out_ready = 0 and present 3 back-to-back instructions → first in the output register, second in the skid, in_ready = 0. Raise out_ready → outputs emerge in order, no loss or duplication.
- Illegal and flush: instr 0x00000000 and 0xFFFFFFFF → out_illegal = 1, we = 0. Flush with 2 entries buffered → out_valid = 0 next cycle and no stale entry afterwards.
